// File: rtl/pipo_arb_pkg.sv
// pipo_arb_pkg: shared types and helpers for the pipo sharing arbiter.
//   state_t        - arbiter FSM states
//   onehot()       - index to one-hot vector (up to PIPO_ARB_MAXN bits)
//   PIPO_ARB_NREQ  - default requester count
package pipo_arb_pkg;

    localparam int PIPO_ARB_NREQ = 4;
    localparam int PIPO_ARB_MAXN = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Bits at or above n stay clear so callers can truncate safely.
    function automatic logic [PIPO_ARB_MAXN-1:0] onehot(input int unsigned idx,
                                                        input int unsigned n);
        logic [PIPO_ARB_MAXN-1:0] v;
        v = '0;
        if (idx < n && idx < PIPO_ARB_MAXN)
            v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pipo_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   eligible [NREQ] - candidate bitmap
//   pointer  [IDW]  - highest-priority index this cycle (must be < NREQ)
//   found           - some eligible bit is set
//   win      [IDW]  - first eligible index at or after pointer, wrapping
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IDW-1:0]  pointer,
    output logic            found,
    output logic [IDW-1:0]  win
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest eligible index
    // is the last one written.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(pointer) + k) % NREQ;
            if (eligible[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/pipo_arbiter.sv
// pipo_arbiter: round-robin sharing of one WIDTH-bit pipo register among
// NREQ requesters. Drives the pipo en/in_data and tracks ownership.
//   clk, rst         - clock, synchronous active-high reset
//   req [NREQ]       - write requests
//   wr_data          - packed write data, requester i at [i*WIDTH +: WIDTH]
//   clr              - invalidate owner_valid
//   gnt [NREQ]       - registered one-hot grant
//   reg_en, reg_data - to pipo en / in_data
//   owner, owner_valid - last writer and whether the pipo value is valid
//   busy             - FSM in GRANT
module pipo_arbiter
    import pipo_arb_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = PIPO_ARB_NREQ,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wr_data,
    input  logic                  clr,
    output logic [NREQ-1:0]       gnt,
    output logic                  reg_en,
    output logic [WIDTH-1:0]      reg_data,
    output logic [IDW-1:0]        owner,
    output logic                  owner_valid,
    output logic                  busy
);

    state_t           state, state_nx;
    logic [IDW-1:0]   ptr, ptr_nx;
    logic [NREQ-1:0]  eligible;
    logic             found;
    logic [IDW-1:0]   win;
    logic [WIDTH-1:0] win_data;

    // The requester holding the grant this cycle sits out the next pick,
    // giving it a cycle to drop req.
    assign eligible = req & ~gnt;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .eligible (eligible),
        .pointer  (ptr),
        .found    (found),
        .win      (win)
    );

    // Only the winner's slice is read, so X on other slices cannot leak.
    assign win_data = wr_data[win*WIDTH +: WIDTH];
    assign ptr_nx   = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found)  state_nx = GRANT;
            GRANT:   if (!found) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == GRANT);

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt         <= '0;
            reg_en      <= 1'b0;
            reg_data    <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            ptr         <= '0;
        end else if (found) begin
            gnt         <= NREQ'(onehot(32'(win), NREQ));
            reg_en      <= 1'b1;
            reg_data    <= win_data;
            owner       <= win;
            owner_valid <= 1'b1;   // a same-edge clr loses to the write
            ptr         <= ptr_nx;
        end else begin
            gnt    <= '0;
            reg_en <= 1'b0;
            if (clr)
                owner_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipo_arbiter.sv
// tb_pipo_arbiter: scoreboard bench for pipo_arbiter with a behavioural pipo.
module tb_pipo_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wr_data;
    logic                  clr;
    logic [NREQ-1:0]       gnt;
    logic                  reg_en;
    logic [WIDTH-1:0]      reg_data;
    logic [IDW-1:0]        owner;
    logic                  owner_valid;
    logic                  busy;
    logic [WIDTH-1:0]      pipo_q;

    always #5 clk = ~clk;

    pipo_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .wr_data     (wr_data),
        .clr         (clr),
        .gnt         (gnt),
        .reg_en      (reg_en),
        .reg_data    (reg_data),
        .owner       (owner),
        .owner_valid (owner_valid),
        .busy        (busy)
    );

    // Stand-in for the downstream pipo (its rst_n is ~rst).
    always @(posedge clk) begin
        if (rst)
            pipo_q <= '0;
        else if (reg_en)
            pipo_q <= reg_data;
    end

    typedef struct packed {
        logic [3:0] gnt;
        logic       en;
        logic [7:0] data;
        logic [1:0] owner;
        logic       ov;
        logic       busy;
        logic [7:0] pipo;
    } exp_t;

    exp_t sb[$];

    logic [3:0] m_gnt   = '0;
    logic       m_en    = 1'b0;
    logic [7:0] m_data  = '0;
    logic [1:0] m_owner = '0;
    logic       m_ov    = 1'b0;
    logic [7:0] m_pipo  = '0;
    int         m_ptr   = 0;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, then compare.
    task automatic step(input logic [3:0] r, input logic [31:0] d,
                        input logic c, input logic rs);
        exp_t       e;
        logic [3:0] el;
        logic [7:0] dbl;
        logic [3:0] rot;
        int         j;
        int         w;
        @(negedge clk);
        req = r; wr_data = d; clr = c; rst = rs;
        if (rs)        m_pipo = '0;
        else if (m_en) m_pipo = m_data;
        if (rs) begin
            m_gnt = '0; m_en = 1'b0; m_data = '0; m_owner = '0; m_ov = 1'b0; m_ptr = 0;
        end else begin
            el  = r & ~m_gnt;
            dbl = {el, el};
            rot = 4'(dbl >> m_ptr);
            if (rot == 4'b0000) begin
                m_gnt = '0;
                m_en  = 1'b0;
                if (c) m_ov = 1'b0;
            end else begin
                j = 0;
                while (!rot[j]) j++;
                w       = (m_ptr + j) % 4;
                m_gnt   = 4'(1 << w);
                m_en    = 1'b1;
                m_data  = d[w*8 +: 8];
                m_owner = 2'(w);
                m_ov    = 1'b1;
                m_ptr   = (w + 1) % 4;
            end
        end
        e.gnt = m_gnt; e.en = m_en; e.data = m_data; e.owner = m_owner;
        e.ov = m_ov; e.busy = (m_gnt != 0); e.pipo = m_pipo;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("gnt",         32'(gnt),         32'(e.gnt));
        chk("reg_en",      32'(reg_en),      32'(e.en));
        chk("reg_data",    32'(reg_data),    32'(e.data));
        chk("owner",       32'(owner),       32'(e.owner));
        chk("owner_valid", 32'(owner_valid), 32'(e.ov));
        chk("busy",        32'(busy),        32'(e.busy));
        chk("pipo",        32'(pipo_q),      32'(e.pipo));
    endtask

    initial begin
        logic [31:0] dx;
        int          last[4];
        int          maxw;
        rst = 1'b1; req = '0; wr_data = '0; clr = 1'b0;

        // reset held with all requesting, then first grant to 0
        step(4'b1111, 32'h13121110, 1'b0, 1'b1);
        chk("t1_rst_gnt", 32'(gnt), 32'h0);
        step(4'b1111, 32'h13121110, 1'b0, 1'b1);
        chk("t1_rst_ov", 32'(owner_valid), 32'h0);
        step(4'b1111, 32'h13121110, 1'b0, 1'b0);
        chk("t1_first", 32'(gnt), 32'h1);
        step(4'b0000, 32'h0, 1'b0, 1'b0);

        // single requester, other slices X
        dx = 'x;
        dx[2*8 +: 8] = 8'hA5;
        step(4'b0100, dx, 1'b0, 1'b0);
        chk("t2_gnt", 32'(gnt), 32'h4);
        chk("t2_data", 32'(reg_data), 32'hA5);
        step(4'b0000, dx, 1'b0, 1'b0);
        chk("t2_drop", 32'(gnt), 32'h0);
        chk("t2_pipo", 32'(pipo_q), 32'hA5);
        chk("t2_owner", 32'(owner), 32'h2);

        // all requesting continuously from a fresh pointer
        step(4'b0000, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) last[i] = -1;
        maxw = 0;
        for (int k = 0; k < 12; k++) begin
            step(4'b1111, 32'h13121110, 1'b0, 1'b0);
            chk("t3_order", 32'(gnt), 32'(1 << (k % 4)));
            chk("t3_data", 32'(reg_data), 32'h10 + 32'(k % 4));
            for (int i = 0; i < 4; i++)
                if (gnt[i]) begin
                    if (k - last[i] > maxw) maxw = k - last[i];
                    last[i] = k;
                end
        end
        chk("t3_maxwait", 32'(maxw <= 5), 32'h1);
        step(4'b0000, 32'h0, 1'b0, 1'b0);

        // lone continuous requester gets every other cycle
        for (int k = 0; k < 8; k++) begin
            step(4'b0010, 32'h00003C00, 1'b0, 1'b0);
            chk("t4_gnt", 32'(gnt), (k % 2 == 0) ? 32'h2 : 32'h0);
            chk("t4_en", 32'(reg_en), (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        step(4'b0000, 32'h0, 1'b0, 1'b0);

        // clr while idle, then clr coinciding with a grant
        step(4'b0000, 32'h0, 1'b1, 1'b0);
        chk("t5_clr_ov", 32'(owner_valid), 32'h0);
        chk("t5_clr_pipo", 32'(pipo_q), 32'h3C);
        step(4'b1000, 32'h77000000, 1'b1, 1'b0);
        chk("t5_both_ov", 32'(owner_valid), 32'h1);
        chk("t5_both_owner", 32'(owner), 32'h3);

        // reset during a grant cycle
        step(4'b1111, 32'h13121110, 1'b0, 1'b0);
        chk("t6_busy", 32'(busy), 32'h1);
        step(4'b1111, 32'h13121110, 1'b0, 1'b1);
        chk("t6_rst_gnt", 32'(gnt), 32'h0);
        chk("t6_rst_data", 32'(reg_data), 32'h0);
        step(4'b1010, 32'h13121110, 1'b0, 1'b0);
        chk("t6_first", 32'(gnt), 32'h2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipo_arbiter.md
Name: pipo_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit pipo register among NREQ requesters. It sits directly in front of an existing pipo instance and drives that register's en and in_data ports. It tracks which requester last wrote the register and whether the stored value is valid. The integration top inverts rst into the pipo's rst_n.

Parameters:
WIDTH, 8, data width; equals the pipo WIDTH.
NREQ, 4, number of requesters, 2..16.
IDW, $clog2(NREQ), requester id width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
req  input  NREQ  write request; bit i belongs to requester i.
wr_data  input  NREQ*WIDTH  packed write data; requester i uses [i*WIDTH +: WIDTH].
clr  input  1  invalidate the stored value (owner_valid <= 0).
gnt  output  NREQ  one-hot grant, registered; all zeros when no grant.
reg_en  output  1  to pipo en; high exactly when gnt != 0.
reg_data  output  WIDTH  to pipo in_data; the granted requester's data, registered.
owner  output  IDW  id of the last granted requester.
owner_valid  output  1  the register holds a value written since reset or clr.
busy  output  1  high in the GRANT state.

Behaviour:
- Reset (rst sampled high at a rising edge): gnt=0, reg_en=0, reg_data=0, owner=0, owner_valid=0, busy=0, rr pointer=0, state=IDLE. rst overrides everything, including mid-grant; a grant cycle in progress is dropped.
- States:
  - IDLE: enter GRANT if eligible != 0, else stay in IDLE.
  - GRANT: one cycle per transfer. Stay in GRANT if eligible != 0, else return to IDLE.
- Eligibility: eligible = req & ~gnt. The requester granted in the current cycle cannot win the next cycle, which gives it one cycle to drop req.
- Arbitration: scan from rr pointer p upward, wrapping modulo NREQ. The first set bit of eligible wins (index w).
- At the edge where a winner exists:
  - gnt <= onehot(w), reg_en <= 1, reg_data <= wr_data[w].
  - p <= (w+1) mod NREQ, wrapping at NREQ-1 -> 0.
  - owner <= w, owner_valid <= 1.
- At the edge where no winner exists: gnt <= 0, reg_en <= 0. reg_data, owner and p hold.
- Latency: req[i] sampled high at edge k -> gnt[i], reg_en and reg_data valid during cycle k..k+1 -> pipo captures at edge k+1 -> pipo out_data is updated after edge k+1.
- Handshake:
  - A transfer is complete at the edge that ends the cycle in which gnt[i] is high.
  - The requester holds req[i] and wr_data constant until it sees gnt[i].
  - It deasserts req[i] in the cycle after gnt[i] is high, or keeps it high to request another write.
  - A lone continuous requester is granted every other cycle.
- Fairness: with all NREQ requesting continuously, each requester is granted at least once every NREQ+1 cycles. No starvation.
- clr: owner_valid <= 0 at the edge it is sampled. If a grant is issued at the same edge, the grant wins (owner_valid <= 1). clr does not touch the pipo contents.
- wr_data of requesters that are not granted is ignored. X on a non-granted slice must not propagate to reg_data.

Decomposition:
- Package pipo_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the function onehot(idx, n);
  - a default constant PIPO_ARB_NREQ=4.
- One sub-module, rr_pick. It is purely combinational:
  - inputs: eligible[NREQ], pointer[IDW];
  - outputs: found, win[IDW].
  - It is reused by future pipo/sipo sharing logic.
- Top-level FSM, registers and data mux live in pipo_arbiter.

Test Plan:
1. Assert rst for 2 cycles with req=4'b1111 -> gnt=0, reg_en=0, owner_valid=0 throughout; first grant goes to gnt=4'b0001 on the cycle after rst falls.
2. Single requester: req[2]=1 with data 8'hA5 for one cycle, then dropped after gnt -> gnt=4'b0100 for exactly 1 cycle, reg_data=8'hA5, pipo out_data=8'hA5 on the next edge, owner=2, owner_valid=1.
3. All requesting continuously, data i -> 8'h10+i -> grant order 0,1,2,3,0,...; reg_data sequence 10,11,12,13. No requester waits more than 5 cycles.
4. Lone continuous req[1] with data 8'h3C -> gnt toggles 0010/0000 every cycle; reg_en follows the same pattern.
5. clr pulse while idle -> owner_valid 1->0 and pipo out_data unchanged. clr at the same edge as a grant to requester 3 -> owner_valid stays 1, owner=3.
6. rst asserted during a GRANT cycle -> gnt, reg_en and reg_data are 0 next cycle, pointer is 0; with req=4'b1010 afterwards, requester 1 wins first.
